// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FP cluster definitions: function codes,
// default unit latencies and unit-sharing helpers.
package fpu_issue_ctrl_pkg;

  localparam logic [2:0] F_NOP    = 3'd0;
  localparam logic [2:0] F_AddSub = 3'd1;
  localparam logic [2:0] F_Mul    = 3'd2;
  localparam logic [2:0] F_Div    = 3'd3;
  localparam logic [2:0] F_Sqrt   = 3'd4;
  localparam logic [2:0] F_AbsOpp = 3'd5;
  localparam logic [2:0] F_Trns   = 3'd6;

  localparam int ADD_LAT_D  = 2;
  localparam int MUL_LAT_D  = 3;
  localparam int DIV_LAT_D  = 8;
  localparam int SQRT_LAT_D = 10;
  localparam int MAX_LAT_D  = 10;

  // AbsOpp is replicated per slot; NOP uses no unit
  function automatic logic is_shared(
    input logic [2:0] op
  );
    return (op != F_NOP) && (op != F_AbsOpp);
  endfunction

endpackage

// File: rtl/fpu_wb_track.sv
// Per-result-port reservation shift register and
// completion pipeline feeding the registered writeback.
module fpu_wb_track
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 10,
  parameter int LW      = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LW-1:0]     lat,
  input  logic              issue,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] dst,
  output logic              can_reserve,
  output logic              wb_en,
  output logic [2:0]        wb_op,
  output logic [REG_AW-1:0] wb_dst
);

  // entry i completes i+1 cycles after the current one
  logic [MAX_LAT-1:0] res;
  logic [2:0]         pop  [MAX_LAT];
  logic [REG_AW-1:0]  pdst [MAX_LAT];

  logic [MAX_LAT-1:0] cur_v;
  logic [2:0]         cur_op  [MAX_LAT];
  logic [REG_AW-1:0]  cur_dst [MAX_LAT];

  // check the slot at offset lat and merge a new issue into it
  always_comb begin
    cur_v       = res;
    cur_op      = pop;
    cur_dst     = pdst;
    can_reserve = 1'b1;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (lat == LW'(i + 1)) begin
        can_reserve = !res[i];
        if (issue) begin
          cur_v[i]   = 1'b1;
          cur_op[i]  = op;
          cur_dst[i] = dst;
        end
      end
    end
  end

  // advance one cycle; offset 0 becomes the writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res    <= '0;
      wb_en  <= 1'b0;
      wb_op  <= F_NOP;
      wb_dst <= '0;
      for (int i = 0; i < MAX_LAT; i++) begin
        pop[i]  <= F_NOP;
        pdst[i] <= '0;
      end
    end else begin
      res    <= cur_v >> 1;
      wb_en  <= cur_v[0];
      wb_op  <= cur_v[0] ? cur_op[0] : F_NOP;
      wb_dst <= cur_v[0] ? cur_dst[0] : '0;
      for (int i = 0; i < MAX_LAT - 1; i++) begin
        pop[i]  <= cur_op[i+1];
        pdst[i] <= cur_dst[i+1];
      end
      pop[MAX_LAT-1]  <= F_NOP;
      pdst[MAX_LAT-1] <= '0;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Two-slot FP issue and writeback scheduler:
// unit/port hazard checks, pending retry, result steering.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ADD_LAT  = ADD_LAT_D,
  parameter int MUL_LAT  = MUL_LAT_D,
  parameter int DIV_LAT  = DIV_LAT_D,
  parameter int SQRT_LAT = SQRT_LAT_D,
  parameter int MAX_LAT  = MAX_LAT_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bundle_valid,
  output logic              bundle_ready,
  input  logic [2:0]        op1,
  input  logic [2:0]        op2,
  input  logic [REG_AW-1:0] dst1,
  input  logic [REG_AW-1:0] dst2,
  output logic [2:0]        InSel1,
  output logic [2:0]        InSel2,
  output logic [2:0]        OutSel1,
  output logic [2:0]        OutSel2,
  output logic              wb1_en,
  output logic              wb2_en,
  output logic [REG_AW-1:0] wb1_dst,
  output logic [REG_AW-1:0] wb2_dst,
  output logic              div_busy,
  output logic              sqrt_busy
);

  localparam int LW = $clog2(MAX_LAT + 1);

  if (ADD_LAT < 1 || ADD_LAT > MAX_LAT ||
      MUL_LAT < 1 || MUL_LAT > MAX_LAT ||
      DIV_LAT < 1 || DIV_LAT > MAX_LAT ||
      SQRT_LAT < 1 || SQRT_LAT > MAX_LAT ||
      MAX_LAT < 1) begin : g_lat_bad
    $error("fpu_issue_ctrl: latency out of 1..MAX_LAT");
  end

  function automatic logic [LW-1:0] lat_of(
    input logic [2:0] op
  );
    logic [LW-1:0] l;
    l = '0;
    case (op)
      F_AddSub: l = LW'(ADD_LAT);
      F_Mul:    l = LW'(MUL_LAT);
      F_Div:    l = LW'(DIV_LAT);
      F_Sqrt:   l = LW'(SQRT_LAT);
      F_AbsOpp: l = LW'(1);
      F_Trns:   l = LW'(1);
      default:  l = '0;
    endcase
    return l;
  endfunction

  logic              p1_v, p2_v;
  logic [2:0]        p1_op, p2_op;
  logic [REG_AW-1:0] p1_dst, p2_dst;
  logic [LW-1:0]     div_cnt, sqrt_cnt;

  logic              accept;
  logic [2:0]        c1, c2;
  logic [REG_AW-1:0] cd1, cd2;
  logic [LW-1:0]     lat1, lat2;
  logic              free1, free2;
  logic              can1, can2;
  logic              issue1, issue2;
  logic              div_go, sqrt_go;

  // candidate per slot: pending op first, else the offered one
  always_comb begin
    bundle_ready = !p1_v && !p2_v;
    accept = bundle_valid && bundle_ready;
    c1  = p1_v ? p1_op  : (accept ? op1  : F_NOP);
    cd1 = p1_v ? p1_dst : (accept ? dst1 : '0);
    c2  = p2_v ? p2_op  : (accept ? op2  : F_NOP);
    cd2 = p2_v ? p2_dst : (accept ? dst2 : '0);
    lat1 = lat_of(c1);
    lat2 = lat_of(c2);
  end

  // hazard checks; slot 1 wins a shared unit
  always_comb begin
    free1 = !((c1 == F_Div  && div_cnt  != '0) ||
              (c1 == F_Sqrt && sqrt_cnt != '0));
    free2 = !((c2 == F_Div  && div_cnt  != '0) ||
              (c2 == F_Sqrt && sqrt_cnt != '0));
    issue1 = (c1 != F_NOP) && free1 && can1;
    issue2 = (c2 != F_NOP) && free2 && can2 &&
             !(issue1 && c1 == c2 && is_shared(c2));
    InSel1 = issue1 ? c1 : F_NOP;
    InSel2 = issue2 ? c2 : F_NOP;
    div_go  = (issue1 && c1 == F_Div)  ||
              (issue2 && c2 == F_Div);
    sqrt_go = (issue1 && c1 == F_Sqrt) ||
              (issue2 && c2 == F_Sqrt);
    div_busy  = div_cnt  != '0;
    sqrt_busy = sqrt_cnt != '0;
  end

  // pending capture on accept, release on issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v   <= 1'b0;
      p1_op  <= F_NOP;
      p1_dst <= '0;
      p2_v   <= 1'b0;
      p2_op  <= F_NOP;
      p2_dst <= '0;
    end else begin
      if (p1_v) begin
        if (issue1) p1_v <= 1'b0;
      end else if (accept && op1 != F_NOP && !issue1) begin
        p1_v   <= 1'b1;
        p1_op  <= op1;
        p1_dst <= dst1;
      end
      if (p2_v) begin
        if (issue2) p2_v <= 1'b0;
      end else if (accept && op2 != F_NOP && !issue2) begin
        p2_v   <= 1'b1;
        p2_op  <= op2;
        p2_dst <= dst2;
      end
    end
  end

  // busy counters reach zero exactly when a reissue is legal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      sqrt_cnt <= '0;
    end else begin
      if (div_go)
        div_cnt <= LW'(DIV_LAT - 1);
      else if (div_cnt != '0)
        div_cnt <= div_cnt - LW'(1);
      if (sqrt_go)
        sqrt_cnt <= LW'(SQRT_LAT - 1);
      else if (sqrt_cnt != '0)
        sqrt_cnt <= sqrt_cnt - LW'(1);
    end
  end

  fpu_wb_track #(
    .REG_AW  (REG_AW),
    .MAX_LAT (MAX_LAT),
    .LW      (LW)
  ) u_port1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .lat         (lat1),
    .issue       (issue1),
    .op          (c1),
    .dst         (cd1),
    .can_reserve (can1),
    .wb_en       (wb1_en),
    .wb_op       (OutSel1),
    .wb_dst      (wb1_dst)
  );

  fpu_wb_track #(
    .REG_AW  (REG_AW),
    .MAX_LAT (MAX_LAT),
    .LW      (LW)
  ) u_port2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .lat         (lat2),
    .issue       (issue2),
    .op          (c2),
    .dst         (cd2),
    .can_reserve (can2),
    .wb_en       (wb2_en),
    .wb_op       (OutSel2),
    .wb_dst      (wb2_dst)
  );

endmodule
